// File: rtl/adbg_cpu_run_ctrl_if.sv
// adbg_cpu_run_ctrl_if
//   Host command channel of the per-core run/halt/step controller. The host
//   is the master. The controller is the slave.
//   Commands are already synchronised into the CPU clock domain.
//
// Signals
//   cmd_valid_i  master -> slave  command valid
//   cmd_ready_o  slave -> master  command accepted when valid & ready
//   cmd_op_i     master -> slave  0 NOP, 1 STALL, 2 RUN, 3 STEP
//   cmd_mask_i   master -> slave  cores targeted by the command
//   cmd_cnt_i    master -> slave  instructions to step (STEP only)
//
// The signal names keep their _i/_o suffixes. The suffix gives the direction
// as seen from the controller, so the names line up with the original port list.
interface adbg_cpu_run_ctrl_if #(
  parameter int NB_CORES = 4,
  parameter int STEP_W   = 8
);
  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic [1:0]          cmd_op_i;
  logic [NB_CORES-1:0] cmd_mask_i;
  logic [STEP_W-1:0]   cmd_cnt_i;

  modport master (
    output cmd_valid_i,
    output cmd_op_i,
    output cmd_mask_i,
    output cmd_cnt_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i,
    input  cmd_op_i,
    input  cmd_mask_i,
    input  cmd_cnt_i,
    output cmd_ready_o
  );
endinterface

// File: rtl/adbg_cpu_run_ctrl.sv
// adbg_cpu_run_ctrl
//   Per-core run/halt/single-step controller for multi-core debug. The whole
//   block runs in the CPU clock domain. Breakpoints halt cores and record the
//   cause. STEP releases a halted core for a programmed number of retired
//   instructions and then halts it again.
//
// Optional build macro
//   ADBG_XTRIG_EN  enables cross-trigger halt. A breakpoint on a core in
//                  group_mask_i halts the other running or stepping group
//                  members one cycle later, with cause XTRIG. When the macro
//                  is undefined, group_mask_i is ignored.
//
// Ports
//   cpu_clk_i     clock
//   cpu_rstn_i    asynchronous active-low reset
//   cmd           host command channel (adbg_cpu_run_ctrl_if.slave)
//   bp_i          per-core breakpoint hit, level
//   retire_i      per-core "one instruction retired this cycle"
//   group_mask_i  cross-trigger group
//   cpu_stall_o   stall request to cores (combinational with bp_i)
//   halted_o      core is HALTED (registered)
//   cause_o       halt cause, core i at [3i+2:3i]
//                 0 NONE, 1 HOST, 2 BP, 3 STEP, 4 XTRIG
//   halt_evt_o    one-cycle pulse on each entry to HALTED
//
// Per-core FSM
//   state       | meaning
//   ST_RUN      | core free-running, not stalled
//   ST_HALTED   | core stalled, waiting for RUN or STEP
//   ST_STEPPING | core released until the step counter is used up
module adbg_cpu_run_ctrl #(
  parameter int NB_CORES   = 4,
  parameter int STEP_W     = 8,
  parameter int RESET_HALT = 0
) (
  input  logic                  cpu_clk_i,
  input  logic                  cpu_rstn_i,
  adbg_cpu_run_ctrl_if.slave    cmd,
  input  logic [NB_CORES-1:0]   bp_i,
  input  logic [NB_CORES-1:0]   retire_i,
  input  logic [NB_CORES-1:0]   group_mask_i,
  output logic [NB_CORES-1:0]   cpu_stall_o,
  output logic [NB_CORES-1:0]   halted_o,
  output logic [3*NB_CORES-1:0] cause_o,
  output logic [NB_CORES-1:0]   halt_evt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALTED   = 2'd1,
    ST_STEPPING = 2'd2
  } state_e;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_HOST  = 3'd1;
  localparam logic [2:0] CAUSE_BP    = 3'd2;
  localparam logic [2:0] CAUSE_STEP  = 3'd3;
  localparam logic [2:0] CAUSE_XTRIG = 3'd4;

  localparam logic [1:0] OP_STALL = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;
  localparam logic [1:0] OP_STEP  = 2'd3;

  localparam state_e              RST_STATE  = (RESET_HALT != 0) ? ST_HALTED  : ST_RUN;
  localparam logic [2:0]          RST_CAUSE  = (RESET_HALT != 0) ? CAUSE_HOST : CAUSE_NONE;
  localparam logic [NB_CORES-1:0] RST_HALTED = (RESET_HALT != 0) ? '1 : '0;
  localparam logic [STEP_W-1:0]   CNT_ZERO   = '0;
  localparam logic [STEP_W-1:0]   CNT_ONE    = {{(STEP_W-1){1'b0}}, 1'b1};

  state_e              state_q [NB_CORES];
  state_e              state_d [NB_CORES];
  logic [STEP_W-1:0]   cnt_q   [NB_CORES];
  logic [STEP_W-1:0]   cnt_d   [NB_CORES];
  logic [2:0]          cause_q [NB_CORES];
  logic [2:0]          cause_d [NB_CORES];
  logic [NB_CORES-1:0] halted_q;
  logic [NB_CORES-1:0] evt_q;
  logic [NB_CORES-1:0] xtrig_hit;
  logic                any_step;
  logic                cmd_acc;

  // Commands are held off while any core steps. A step is therefore never
  // disturbed by a host command, and the host sees one completion at a time.
  always_comb begin
    any_step = 1'b0;
    for (int i = 0; i < NB_CORES; i++) begin
      if (state_q[i] == ST_STEPPING) any_step = 1'b1;
    end
  end

  assign cmd.cmd_ready_o = ~any_step;
  assign cmd_acc         = cmd.cmd_valid_i & ~any_step;

`ifdef ADBG_XTRIG_EN
  // This register records which group members must halt on the next cycle.
  // A core that hits its own breakpoint is left out of the mask, so it keeps
  // cause BP.
  logic [NB_CORES-1:0] xtrig_q;

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      xtrig_q <= '0;
    end else if ((bp_i & group_mask_i) != '0) begin
      xtrig_q <= group_mask_i & ~bp_i;
    end else begin
      xtrig_q <= '0;
    end
  end

  assign xtrig_hit = xtrig_q;
`else
  logic unused_group_mask;

  assign unused_group_mask = ^group_mask_i;
  assign xtrig_hit         = '0;
`endif

  // Next-state logic. Priority within a core is:
  // bp_i, then cross-trigger, then host command, then retire.
  always_comb begin
    for (int i = 0; i < NB_CORES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      cause_d[i] = cause_q[i];

      case (state_q[i])
        ST_RUN: begin
          if (bp_i[i]) begin
            state_d[i] = ST_HALTED;
            cause_d[i] = CAUSE_BP;
          end else if (xtrig_hit[i]) begin
            state_d[i] = ST_HALTED;
            cause_d[i] = CAUSE_XTRIG;
          end else if (cmd_acc && cmd.cmd_mask_i[i] && cmd.cmd_op_i == OP_STALL) begin
            state_d[i] = ST_HALTED;
            cause_d[i] = CAUSE_HOST;
          end
        end

        ST_HALTED: begin
          if (cmd_acc && cmd.cmd_mask_i[i]) begin
            // A breakpoint that arrives with a release command wins. The core
            // stays halted, but the cause is updated so the host can see why.
            if (cmd.cmd_op_i == OP_RUN) begin
              if (bp_i[i]) begin
                cause_d[i] = CAUSE_BP;
              end else begin
                state_d[i] = ST_RUN;
                cause_d[i] = CAUSE_NONE;
              end
            end else if (cmd.cmd_op_i == OP_STEP && cmd.cmd_cnt_i != CNT_ZERO) begin
              if (bp_i[i]) begin
                cause_d[i] = CAUSE_BP;
              end else begin
                state_d[i] = ST_STEPPING;
                cnt_d[i]   = cmd.cmd_cnt_i;
              end
            end
          end
        end

        ST_STEPPING: begin
          if (bp_i[i]) begin
            state_d[i] = ST_HALTED;
            cause_d[i] = CAUSE_BP;
            cnt_d[i]   = CNT_ZERO;
          end else if (xtrig_hit[i]) begin
            state_d[i] = ST_HALTED;
            cause_d[i] = CAUSE_XTRIG;
            cnt_d[i]   = CNT_ZERO;
          end else if (retire_i[i] && cnt_q[i] != CNT_ZERO) begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
            if (cnt_q[i] == CNT_ONE) begin
              state_d[i] = ST_HALTED;
              cause_d[i] = CAUSE_STEP;
            end
          end
        end

        default: begin
          state_d[i] = RST_STATE;
          cnt_d[i]   = CNT_ZERO;
          cause_d[i] = RST_CAUSE;
        end
      endcase
    end
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      for (int i = 0; i < NB_CORES; i++) begin
        state_q[i] <= RST_STATE;
        cnt_q[i]   <= CNT_ZERO;
        cause_q[i] <= RST_CAUSE;
      end
      halted_q <= RST_HALTED;
      evt_q    <= '0;
    end else begin
      for (int i = 0; i < NB_CORES; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        cause_q[i]  <= cause_d[i];
        halted_q[i] <= (state_d[i] == ST_HALTED);
        evt_q[i]    <= (state_d[i] == ST_HALTED) && (state_q[i] != ST_HALTED);
      end
    end
  end

  // The stall is combinational on bp_i. The core then freezes in the same
  // cycle as the breakpoint, before halted_o goes high.
  assign cpu_stall_o = bp_i | halted_q;
  assign halted_o    = halted_q;
  assign halt_evt_o  = evt_q;

  always_comb begin
    cause_o = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      cause_o[3*i +: 3] = cause_q[i];
    end
  end

endmodule

// File: tb/tb_adbg_cpu_run_ctrl.sv
// tb_adbg_cpu_run_ctrl
//   Directed bench for adbg_cpu_run_ctrl.
//   The reference model tracks three things per core: a halted flag, the
//   number of steps still owed, and the cause. A compare process checks every
//   DUT output against this model on each negative clock edge.
//   Literal checks at key points pin the model itself.
//   A second instance, built with RESET_HALT=1, checks only its reset state.
module tb_adbg_cpu_run_ctrl;
  localparam int NB = 4;
  localparam int SW = 8;

  logic cpu_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  adbg_cpu_run_ctrl_if #(.NB_CORES(NB), .STEP_W(SW)) cmd_if ();
  adbg_cpu_run_ctrl_if #(.NB_CORES(NB), .STEP_W(SW)) rh_if ();

  logic [NB-1:0]   bp, retire, grp;
  logic [NB-1:0]   stall, halted, evt;
  logic [3*NB-1:0] cause;

  logic [NB-1:0]   rh_zero;
  logic [NB-1:0]   rh_stall, rh_halted, rh_evt;
  logic [3*NB-1:0] rh_cause;

  adbg_cpu_run_ctrl #(.NB_CORES(NB), .STEP_W(SW), .RESET_HALT(0)) dut (
    .cpu_clk_i   (cpu_clk),
    .cpu_rstn_i  (rst_n),
    .cmd         (cmd_if.slave),
    .bp_i        (bp),
    .retire_i    (retire),
    .group_mask_i(grp),
    .cpu_stall_o (stall),
    .halted_o    (halted),
    .cause_o     (cause),
    .halt_evt_o  (evt)
  );

  adbg_cpu_run_ctrl #(.NB_CORES(NB), .STEP_W(SW), .RESET_HALT(1)) dut_rh (
    .cpu_clk_i   (cpu_clk),
    .cpu_rstn_i  (rst_n),
    .cmd         (rh_if.slave),
    .bp_i        (rh_zero),
    .retire_i    (rh_zero),
    .group_mask_i(rh_zero),
    .cpu_stall_o (rh_stall),
    .halted_o    (rh_halted),
    .cause_o     (rh_cause),
    .halt_evt_o  (rh_evt)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_h     [NB];
  int          m_steps [NB];
  int          m_cause [NB];
  bit          m_evt   [NB];
  bit [NB-1:0] m_xpend;
  bit [NB-1:0] m_xp;
  bit          m_acc, m_prev, m_sel;

  function automatic bit m_ready();
    for (int i = 0; i < NB; i++) if (m_steps[i] > 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin
        m_h[i] = 1'b0; m_steps[i] = 0; m_cause[i] = 0; m_evt[i] = 1'b0;
      end
      m_xpend = '0;
    end else begin
      m_acc = cmd_if.cmd_valid_i && m_ready();
      m_xp  = m_xpend;
      for (int i = 0; i < NB; i++) begin
        m_prev = m_h[i];
        m_sel  = m_acc && cmd_if.cmd_mask_i[i];
        if (bp[i]) begin
          if (!m_h[i]) begin
            m_h[i] = 1'b1; m_cause[i] = 2; m_steps[i] = 0;
          end else if (m_sel && (cmd_if.cmd_op_i == 2 ||
                                 (cmd_if.cmd_op_i == 3 && cmd_if.cmd_cnt_i != 0))) begin
            m_cause[i] = 2;
          end
        end else if (m_xp[i] && !m_h[i]) begin
          m_h[i] = 1'b1; m_cause[i] = 4; m_steps[i] = 0;
        end else if (m_sel && cmd_if.cmd_op_i == 1 && !m_h[i]) begin
          m_h[i] = 1'b1; m_cause[i] = 1;
        end else if (m_sel && cmd_if.cmd_op_i == 2 && m_h[i]) begin
          m_h[i] = 1'b0; m_cause[i] = 0;
        end else if (m_sel && cmd_if.cmd_op_i == 3 && m_h[i] && cmd_if.cmd_cnt_i != 0) begin
          m_h[i] = 1'b0; m_steps[i] = int'(cmd_if.cmd_cnt_i);
        end else if (m_steps[i] > 0 && retire[i]) begin
          m_steps[i]--;
          if (m_steps[i] == 0) begin
            m_h[i] = 1'b1; m_cause[i] = 3;
          end
        end
        m_evt[i] = m_h[i] && !m_prev;
      end
`ifdef ADBG_XTRIG_EN
      m_xpend = ((bp & grp) != '0) ? (grp & ~bp) : '0;
`else
      m_xpend = '0;
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NB-1:0]   e_h, e_evt;
  logic [3*NB-1:0] e_cause;

  always @(negedge cpu_clk) begin
    if (rst_n && chk_on) begin
      for (int i = 0; i < NB; i++) begin
        e_h[i]           = m_h[i];
        e_evt[i]         = m_evt[i];
        e_cause[3*i +: 3] = 3'(m_cause[i]);
      end
      chk("model_stall",  32'(stall),  32'(bp | e_h));
      chk("model_halted", 32'(halted), 32'(e_h));
      chk("model_cause",  32'(cause),  32'(e_cause));
      chk("model_evt",    32'(evt),    32'(e_evt));
      chk("model_ready",  32'(cmd_if.cmd_ready_o), 32'(m_ready()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [NB-1:0] mask, input logic [SW-1:0] cnt);
    int budget;
    cmd_if.cmd_op_i    = op;
    cmd_if.cmd_mask_i  = mask;
    cmd_if.cmd_cnt_i   = cnt;
    cmd_if.cmd_valid_i = 1'b1;
    budget = 0;
    while (!cmd_if.cmd_ready_o && budget < 200) begin
      tick();
      budget++;
    end
    if (budget >= 200) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout actual=ready_low required=ready_high");
    end
    tick();
    cmd_if.cmd_valid_i = 1'b0;
    cmd_if.cmd_op_i    = 2'd0;
    cmd_if.cmd_mask_i  = '0;
    cmd_if.cmd_cnt_i   = '0;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    bp = '0; retire = '0; grp = '0; rh_zero = '0;
    cmd_if.cmd_valid_i = 1'b0; cmd_if.cmd_op_i = 2'd0;
    cmd_if.cmd_mask_i = '0;    cmd_if.cmd_cnt_i = '0;
    rh_if.cmd_valid_i = 1'b0;  rh_if.cmd_op_i = 2'd0;
    rh_if.cmd_mask_i = '0;     rh_if.cmd_cnt_i = '0;

    // Reset state, both reset flavours
    repeat (3) tick();
    chk("rst_stall",     32'(stall),  32'h0);
    chk("rst_halted",    32'(halted), 32'h0);
    chk("rst_cause",     32'(cause),  32'h0);
    chk("rst_ready",     32'(cmd_if.cmd_ready_o), 32'h1);
    chk("rst_evt",       32'(evt),    32'h0);
    chk("rh_rst_halted", 32'(rh_halted), 32'hF);
    chk("rh_rst_cause",  32'(rh_cause),  32'h249);
    chk("rh_rst_stall",  32'(rh_stall),  32'hF);
    chk("rh_rst_ready",  32'(rh_if.cmd_ready_o), 32'h1);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    tick();
    chk("rh_no_evt_after_rst", 32'(rh_evt), 32'h0);
    tick();
    chk("rh_still_halted", 32'(rh_halted), 32'hF);

    // Breakpoint on core 2 while running
    bp = 4'b0100;
    #1;
    chk("bp_stall_same_cycle", 32'(stall),  32'h4);
    chk("bp_not_yet_halted",   32'(halted), 32'h0);
    tick();
    bp = '0;
    #1;
    chk("bp_halted",  32'(halted),    32'h4);
    chk("bp_evt",     32'(evt),       32'h4);
    chk("bp_cause2",  32'(cause[8:6]), 32'h2);
    tick();
    chk("bp_evt_single", 32'(evt),    32'h0);
    chk("bp_stays",      32'(halted), 32'h4);
    send(2'd2, 4'b0100, '0);
    chk("run_released", 32'(halted), 32'h0);
    chk("run_cause",    32'(cause),  32'h0);

    // STALL all, then step core 0 by 3 with gaps between retires
    send(2'd1, 4'b1111, '0);
    chk("stall_all_halted", 32'(halted), 32'hF);
    chk("stall_all_cause",  32'(cause),  32'h249);
    send(2'd3, 4'b0001, 8'd3);
    chk("step_ready_low", 32'(cmd_if.cmd_ready_o), 32'h0);
    chk("step_running",   32'(halted), 32'hE);
    retire = 4'b0001; tick();
    retire = '0;      tick();
    retire = 4'b0001; tick();
    retire = '0;      tick(); tick();
    chk("step_mid_ready", 32'(cmd_if.cmd_ready_o), 32'h0);
    chk("step_mid_run",   32'(halted), 32'hE);
    retire = 4'b0001; tick();
    retire = '0;
    chk("step_done_halted", 32'(halted),    32'hF);
    chk("step_done_cause",  32'(cause[2:0]), 32'h3);
    chk("step_done_ready",  32'(cmd_if.cmd_ready_o), 32'h1);
    chk("step_done_evt",    32'(evt),       32'h1);

    // Step 5, breakpoint after two retires; then STEP with count 0
    send(2'd3, 4'b0001, 8'd5);
    retire = 4'b0001; tick();
    retire = '0;      tick();
    retire = 4'b0001; tick();
    retire = '0;
    bp = 4'b0001;     tick();
    bp = '0;
    chk("stepbp_halted", 32'(halted),    32'hF);
    chk("stepbp_cause",  32'(cause[2:0]), 32'h2);
    chk("stepbp_ready",  32'(cmd_if.cmd_ready_o), 32'h1);
    send(2'd3, 4'b0001, 8'd0);
    chk("step0_halted", 32'(halted),    32'hF);
    chk("step0_cause",  32'(cause[2:0]), 32'h2);
    chk("step0_ready",  32'(cmd_if.cmd_ready_o), 32'h1);

    // RUN and breakpoint in the same cycle on halted core 1
    cmd_if.cmd_op_i = 2'd2; cmd_if.cmd_mask_i = 4'b0010;
    cmd_if.cmd_cnt_i = '0;  cmd_if.cmd_valid_i = 1'b1;
    bp = 4'b0010;
    tick();
    cmd_if.cmd_valid_i = 1'b0; cmd_if.cmd_op_i = 2'd0; cmd_if.cmd_mask_i = '0;
    bp = '0;
    chk("runbp_halted", 32'(halted),    32'hF);
    chk("runbp_cause",  32'(cause[5:3]), 32'h2);
    chk("runbp_no_evt", 32'(evt),       32'h0);

    // Cross-trigger group 1011, breakpoint on core 0
    send(2'd2, 4'b1111, '0);
    chk("xt_all_run", 32'(halted), 32'h0);
    grp = 4'b1011;
    bp  = 4'b0001;
    tick();
    bp = '0;
    chk("xt_origin_halted", 32'(halted),    32'h1);
    chk("xt_origin_cause",  32'(cause[2:0]), 32'h2);
    tick();
`ifdef ADBG_XTRIG_EN
    chk("xt_group_halted", 32'(halted), 32'hB);
    chk("xt_group_cause",  32'(cause),  32'h822);
    chk("xt_group_evt",    32'(evt),    32'hA);
`else
    chk("xt_off_halted", 32'(halted), 32'h1);
    chk("xt_off_cause",  32'(cause),  32'h002);
    chk("xt_off_evt",    32'(evt),    32'h0);
`endif
    grp = '0;
    tick();

    // Reset in the middle of a step
    send(2'd1, 4'b1111, '0);
    send(2'd3, 4'b0100, 8'd10);
    retire = 4'b0100; tick();
    retire = '0;
    chk("midstep_ready_low", 32'(cmd_if.cmd_ready_o), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready",  32'(cmd_if.cmd_ready_o), 32'h1);
    chk("midrst_halted", 32'(halted), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("after_rst_halted", 32'(halted), 32'h0);
    chk("after_rst_evt",    32'(evt),    32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
